// File: rtl/dpram_display_reader_if.sv
// Port-B bus between the display reader and the dual-port RAM.
// The reader is master; the RAM port B is slave.
interface dpram_display_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  wen_b;
  logic [DATA_WIDTH-1:0] dout_b;

  modport master (
    output addr_b,
    output din_b,
    output wen_b,
    input  dout_b
  );

  modport slave (
    input  addr_b,
    input  din_b,
    input  wen_b,
    output dout_b
  );
endinterface

// File: rtl/dpram_display_reader.sv
// Periodic read-only port-B reader of the board RAM.
// Shows the captured word on a 4-digit multiplexed 7-segment display.
module dpram_display_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int READ_PERIOD = 1000,
  parameter int REFRESH_DIV = 50000,
  parameter int SCAN_LAST   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  auto_scan,
  input  logic [ADDR_WIDTH-1:0] sel_addr,
  dpram_display_reader_if.master ram,
  output logic [DATA_WIDTH-1:0] word,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  cap,
  output logic [3:0]            an,
  output logic [6:0]            seg
);
  localparam int HW = $clog2(READ_PERIOD + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(SCAN_LAST);

  typedef enum logic [1:0] {
    ISSUE, WAIT, CAPTURE, HOLD
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  cap_q;
  logic                  mode_q;
  logic [HW-1:0]         hold_q;
  logic [RW-1:0]         ref_q;
  logic [1:0]            dig_q;
  logic [3:0]            an_q;
  logic [6:0]            seg_q;

  logic [ADDR_WIDTH-1:0] ptr_eff;
  logic [ADDR_WIDTH-1:0] ptr_nxt;
  logic [DATA_WIDTH-1:0] word_d;
  logic [RW-1:0]         ref_d;
  logic [1:0]            dig_d;
  logic [3:0]            nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // an/seg are built from next-state word and digit so they move together
  always_comb begin
    ptr_eff = (ptr_q > LAST) ? '0 : ptr_q;
    ptr_nxt = (ptr_eff == LAST) ? '0 : ptr_eff + 1'b1;
    word_d  = (state_q == CAPTURE) ? ram.dout_b : word_q;
    ref_d   = ref_q + 1'b1;
    dig_d   = dig_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      dig_d = dig_q + 1'b1;
    end
    nib = word_d[{dig_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISSUE;
      addr_q  <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      word_q  <= '0;
      cap_q   <= 1'b0;
      mode_q  <= 1'b0;
      hold_q  <= '0;
      ref_q   <= '0;
      dig_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'h40;
    end else begin
      cap_q <= 1'b0;
      ref_q <= ref_d;
      dig_q <= dig_d;
      an_q  <= ~(4'b0001 << dig_d);
      seg_q <= hex7(nib);
      unique case (state_q)
        ISSUE: begin
          mode_q  <= auto_scan;
          addr_q  <= auto_scan ? ptr_eff : sel_addr;
          state_q <= WAIT;
        end
        WAIT: state_q <= CAPTURE;
        CAPTURE: begin
          word_q  <= ram.dout_b;
          waddr_q <= addr_q;
          cap_q   <= 1'b1;
          if (mode_q) ptr_q <= ptr_nxt;
          hold_q  <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
          if (hold_q == HW'(READ_PERIOD - 1))
            state_q <= ISSUE;
          else
            hold_q <= hold_q + 1'b1;
        end
        default: state_q <= ISSUE;
      endcase
    end
  end

  assign ram.addr_b = addr_q;
  assign ram.din_b  = '0;
  assign ram.wen_b  = 1'b0;
  assign word       = word_q;
  assign word_addr  = waddr_q;
  assign cap        = cap_q;
  assign an         = an_q;
  assign seg        = seg_q;
endmodule

// File: tb/tb_dpram_display_reader.sv
// Directed bench for dpram_display_reader with a registered-read RAM model.
// Small READ_PERIOD/REFRESH_DIV keep every sequence short.
module tb_dpram_display_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        auto_scan = 1'b0;
  logic [9:0]  sel_addr = '0;
  logic [15:0] word;
  logic [9:0]  word_addr;
  logic        cap;
  logic [3:0]  an;
  logic [6:0]  seg;

  dpram_display_reader_if #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16)
  ) bus ();

  dpram_display_reader #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16),
    .READ_PERIOD(2), .REFRESH_DIV(4),
    .SCAN_LAST(10)
  ) dut (
    .clk(clk), .reset(reset),
    .auto_scan(auto_scan), .sel_addr(sel_addr),
    .ram(bus.master),
    .word(word), .word_addr(word_addr),
    .cap(cap), .an(an), .seg(seg)
  );

  logic [15:0] mem [1024];
  always @(posedge clk) bus.dout_b <= mem[bus.addr_b];

  int wr_bad = 0;
  always @(negedge clk)
    if (bus.wen_b !== 1'b0 || bus.din_b !== 16'h0)
      wr_bad++;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
  endtask

  typedef struct {
    logic [9:0]  sel;
    logic [15:0] data;
  } man_t;

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [6:0] seg;
  } disp_t;

  man_t  mv[4];
  disp_t dv[8];

  initial begin
    int n;
    int t;
    int cyc;
    int last;

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mv[0] = '{10'd5,    16'h1234};
    mv[1] = '{10'd7,    16'hBEEF};
    mv[2] = '{10'd1023, 16'hFFFF};
    mv[3] = '{10'd512,  16'hA5C3};
    for (int i = 0; i < 4; i++) mem[mv[i].sel] = mv[i].data;

    dv[0] = '{1,  4'b1110, 7'h40};
    dv[1] = '{3,  4'b1110, 7'h0E};
    dv[2] = '{4,  4'b1101, 7'h06};
    dv[3] = '{7,  4'b1101, 7'h06};
    dv[4] = '{8,  4'b1011, 7'h06};
    dv[5] = '{12, 4'b0111, 7'h03};
    dv[6] = '{15, 4'b0111, 7'h03};
    dv[7] = '{16, 4'b1110, 7'h0E};

    // manual reads
    for (int i = 0; i < 4; i++) begin
      auto_scan = 1'b0;
      sel_addr  = mv[i].sel;
      do_reset();
      chk("rst addr_b", 32'(bus.addr_b), 0);
      chk("rst word", 32'(word), 0);
      chk("rst word_addr", 32'(word_addr), 0);
      chk("rst cap", 32'(cap), 0);
      chk("rst an", 32'(an), 32'b1110);
      chk("rst seg", 32'(seg), 32'h40);
      reset = 1'b0;
      step();
      chk("man addr_b", 32'(bus.addr_b), 32'(mv[i].sel));
      chk("man cap c1", 32'(cap), 0);
      step();
      chk("man cap c2", 32'(cap), 0);
      step();
      chk("man cap c3", 32'(cap), 1);
      chk("man word", 32'(word), 32'(mv[i].data));
      chk("man word_addr", 32'(word_addr), 32'(mv[i].sel));
      step();
      chk("man cap c4", 32'(cap), 0);
    end

    // display mux on BEEF
    sel_addr = 10'd7;
    do_reset();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      while (n < dv[i].n) begin
        step();
        n++;
      end
      chk($sformatf("disp an n=%0d", n), 32'(an), 32'(dv[i].an));
      chk($sformatf("disp seg n=%0d", n), 32'(seg), 32'(dv[i].seg));
    end

    for (int i = 0; i <= 10; i++) mem[i] = 16'(i + 100);

    // sel_addr glitch during HOLD
    sel_addr = 10'd3;
    do_reset();
    reset = 1'b0;
    step(); step(); step();
    chk("glitch first cap", 32'(cap), 1);
    sel_addr = 10'd7;
    step(); step();
    sel_addr = 10'd3;
    t = 0;
    do begin step(); t++; end while (!cap && t < 10);
    chk("glitch cap seen", 32'(cap), 1);
    chk("glitch cap delay", 32'(t), 3);
    chk("glitch word_addr", 32'(word_addr), 3);
    chk("glitch word", 32'(word), 103);

    // reset while in WAIT
    sel_addr = 10'd5;
    do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("midrst cap", 32'(cap), 0);
    chk("midrst word", 32'(word), 0);
    chk("midrst an", 32'(an), 32'b1110);
    chk("midrst seg", 32'(seg), 32'h40);
    chk("midrst addr_b", 32'(bus.addr_b), 0);
    step();
    chk("midrst cap2", 32'(cap), 0);
    chk("midrst word2", 32'(word), 0);
    reset = 1'b0;
    step();
    chk("midrst re addr_b", 32'(bus.addr_b), 5);
    step();
    chk("midrst re cap c2", 32'(cap), 0);
    step();
    chk("midrst re cap c3", 32'(cap), 1);
    chk("midrst re word", 32'(word), 105);

    // auto-scan with wrap
    auto_scan = 1'b1;
    do_reset();
    reset = 1'b0;
    cyc = 0;
    last = 0;
    for (int k = 0; k < 13; k++) begin
      t = 0;
      do begin step(); cyc++; t++; end
      while (!cap && t < 10);
      chk($sformatf("scan cap k=%0d", k), 32'(cap), 1);
      chk($sformatf("scan addr k=%0d", k),
          32'(word_addr), 32'(k % 11));
      chk($sformatf("scan word k=%0d", k),
          32'(word), 32'((k % 11) + 100));
      if (k == 0)
        chk("scan first lat", 32'(cyc), 3);
      else
        chk($sformatf("scan gap k=%0d", k), 32'(cyc - last), 5);
      last = cyc;
    end

    chk("write isolation", 32'(wr_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
